// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : 16x-oversampling UART receiver. Handles 5..8 data bits, optional
//            even/odd parity and 1 or 2 stop bits. Each byte is delivered over
//            a valid/ready handshake with per-frame parity/framing flags.
// Options  : define UART_RX_MAJ_VOTE_EN to take every bit as the 2-of-3
//            majority of ticks 7/8/9 (decision at tick 9) instead of a
//            single sample at tick 8.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             app_clk,
    input  logic             reset_n,
    input  logic             cfg_rx_en,
    input  logic [DIV_W-1:0] cfg_baud_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_stop_bits,
    input  logic             cfg_par_en,
    input  logic             cfg_even_par,
    input  logic             rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_overrun,
    output logic             rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

`ifdef UART_RX_MAJ_VOTE_EN
    localparam logic [3:0] c_start_pt = 4'd8;
`else
    localparam logic [3:0] c_start_pt = 4'd7;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               r_rxs_d;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic [3:0]         r_tick16;
    logic [DIV_W-1:0]   r_baud_div;
    logic [1:0]         r_data_bits;
    logic               r_stop_bits;
    logic               r_par_en;
    logic               r_even_par;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic               r_perr;
    logic               r_ferr;
    logic               w_rxs;
    logic               w_start;
    logic               w_tick;
    logic [3:0]         w_pt;
    logic               w_samp;
    logic               w_bit;
    logic               w_last_bit;
    logic               w_par_exp;
    logic               w_complete;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_start    = (r_state == S_IDLE) && cfg_rx_en && r_rxs_d && !w_rxs;
    assign w_tick     = (r_tick_cnt == '0);
    // Start bit is sampled mid-bit; every later bit one full bit period on.
    assign w_pt       = (r_state == S_START) ? c_start_pt : 4'd15;
    assign w_samp     = w_tick && (r_tick16 == w_pt) && (r_state != S_IDLE);
    assign w_last_bit = (r_bit_idx == ({1'b0, r_data_bits} + 3'd4));
    assign w_par_exp  = r_even_par ? (^r_shift) : ~(^r_shift);
    assign w_complete = cfg_rx_en && w_samp &&
                        (((r_state == S_STOP1) && !r_stop_bits) || (r_state == S_STOP2));
    assign rx_busy    = (r_state != S_IDLE);

    // Bring rxd into the clock domain and keep the previous value for edge detect.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxs_d <= w_rxs;
        end
    end

`ifdef UART_RX_MAJ_VOTE_EN
    logic [1:0] r_vote;

    // Capture the two samples preceding the decision tick for the 2-of-3 vote.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vote <= 2'b11;
        end else if (w_tick) begin
            if (r_tick16 == (w_pt - 4'd2)) r_vote[0] <= w_rxs;
            if (r_tick16 == (w_pt - 4'd1)) r_vote[1] <= w_rxs;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rxs) | (r_vote[1] & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    // Baud tick generator; reloaded on the start edge to phase-align to the frame.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= DIV_W'(1);
        end else if (w_start) begin
            r_tick_cnt <= cfg_baud_div;
        end else if (w_tick) begin
            r_tick_cnt <= (r_state == S_IDLE) ? cfg_baud_div : r_baud_div;
        end else begin
            r_tick_cnt <= r_tick_cnt - DIV_W'(1);
        end
    end

    // Tick position within the current bit; restarts after the start-bit check.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick16 <= 4'd0;
        end else if (w_start) begin
            r_tick16 <= 4'd0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            if (w_samp && (r_state == S_START)) r_tick16 <= 4'd0;
            else                                r_tick16 <= r_tick16 + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; disabling the receiver aborts any frame in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START:  if (w_samp)  w_state_nxt = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_samp && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_samp)  w_state_nxt = S_STOP1;
            S_STOP1:  if (w_samp)  w_state_nxt = r_stop_bits ? S_STOP2 : S_IDLE;
            S_STOP2:  if (w_samp)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (!cfg_rx_en && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    // Frame datapath: latch configuration at the start edge, then assemble bits and flags.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud_div  <= '0;
            r_data_bits <= 2'd0;
            r_stop_bits <= 1'b0;
            r_par_en    <= 1'b0;
            r_even_par  <= 1'b0;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
        end else if (w_start) begin
            r_baud_div  <= cfg_baud_div;
            r_data_bits <= cfg_data_bits;
            r_stop_bits <= cfg_stop_bits;
            r_par_en    <= cfg_par_en;
            r_even_par  <= cfg_even_par;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
        end else if (w_samp) begin
            case (r_state)
                S_DATA: begin
                    r_shift[r_bit_idx] <= w_bit;
                    r_bit_idx          <= r_bit_idx + 3'd1;
                end
                S_PARITY:         r_perr <= (w_bit != w_par_exp);
                S_STOP1, S_STOP2: if (!w_bit) r_ferr <= 1'b1;
                default:          ;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (w_complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_shift;
                    rx_perr  <= r_perr;
                    rx_ferr  <= r_ferr | ~w_bit;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed self-checking bench for uart_rx_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    logic        app_clk = 1'b0;
    logic        reset_n;
    logic        cfg_rx_en;
    logic [15:0] cfg_baud_div;
    logic [1:0]  cfg_data_bits;
    logic        cfg_stop_bits;
    logic        cfg_par_en;
    logic        cfg_even_par;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_overrun;
    logic        rx_busy;

    int tests   = 0;
    int fails   = 0;
    int ovr_cnt = 0;
    int bit_cyc = 64;
    int lat;

    uart_rx_core #(.DIV_W(16), .SYNC_STAGES(2)) dut (
        .app_clk       (app_clk),
        .reset_n       (reset_n),
        .cfg_rx_en     (cfg_rx_en),
        .cfg_baud_div  (cfg_baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop_bits (cfg_stop_bits),
        .cfg_par_en    (cfg_par_en),
        .cfg_even_par  (cfg_even_par),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_perr       (rx_perr),
        .rx_ferr       (rx_ferr),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always #5 app_clk = ~app_clk;

    // Count overrun pulses away from the active edge.
    always @(negedge app_clk) if (rx_overrun === 1'b1) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame LSB first; nsend>0 truncates it, gbit selects a bit that
    // gets a one-cycle inverted glitch at offset 8. Line is left idle high.
    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                              input logic par_bit, input int nstop, input logic s1,
                              input logic s2, input int nsend, input int gbit);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin bits[n] = data[i]; n++; end
        if (par_en) begin bits[n] = par_bit; n++; end
        bits[n] = s1; n++;
        if (nstop == 2) begin bits[n] = s2; n++; end
        if (nsend > 0 && nsend < n) n = nsend;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < bit_cyc; c++) begin
                rxd = bits[i] ^ ((i == gbit && c == 8) ? 1'b1 : 1'b0);
                @(negedge app_clk);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        @(negedge app_clk);
        rx_ready = 1'b0;
        check(tag, rx_valid, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        rxd           = 1'b1;
        rx_ready      = 1'b0;
        cfg_rx_en     = 1'b1;
        cfg_baud_div  = 16'd3;
        cfg_data_bits = 2'd3;
        cfg_stop_bits = 1'b0;
        cfg_par_en    = 1'b0;
        cfg_even_par  = 1'b0;
        repeat (3) @(negedge app_clk);
        check("rst_valid",   rx_valid,   1'b0);
        check("rst_data",    rx_data,    8'h00);
        check("rst_busy",    rx_busy,    1'b0);
        check("rst_overrun", rx_overrun, 1'b0);
        check("rst_perr",    rx_perr,    1'b0);
        check("rst_ferr",    rx_ferr,    1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge app_clk);

        // 8N1 0xA5 with completion latency measured from start of stop bit.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 9, -1);
        lat = -1;
        for (int c = 1; c <= bit_cyc; c++) begin
            @(negedge app_clk);
            if (rx_valid === 1'b1 && lat < 0) lat = c;
        end
`ifdef UART_RX_MAJ_VOTE_EN
        check("a5_latency", lat, 39);
`else
        check("a5_latency", lat, 35);
`endif
        check("a5_valid", rx_valid, 1'b1);
        check("a5_data",  rx_data,  8'hA5);
        check("a5_perr",  rx_perr,  1'b0);
        check("a5_ferr",  rx_ferr,  1'b0);
        accept("a5_accept");

        // 7E1 0x35: parity forced wrong, then correct.
        cfg_data_bits = 2'd2; cfg_par_en = 1'b1; cfg_even_par = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0, 0, -1);
        check("7e1_bad_data", rx_data, 8'h35);
        check("7e1_bad_perr", rx_perr, 1'b1);
        check("7e1_bad_ferr", rx_ferr, 1'b0);
        accept("7e1_bad_accept");
        send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1, 1'b0, 0, -1);
        check("7e1_ok_data", rx_data, 8'h35);
        check("7e1_ok_perr", rx_perr, 1'b0);
        accept("7e1_ok_accept");

        // 5O2 0x1B with second stop bit low; odd parity bit is 1.
        cfg_data_bits = 2'd0; cfg_stop_bits = 1'b1; cfg_even_par = 1'b0;
        send_frame(8'h1B, 5, 1'b1, 1'b1, 2, 1'b1, 1'b0, 0, -1);
        check("5o2_data",  rx_data,  8'h1B);
        check("5o2_perr",  rx_perr,  1'b0);
        check("5o2_ferr",  rx_ferr,  1'b1);
        check("5o2_valid", rx_valid, 1'b1);
        accept("5o2_accept");

        // 8N1 with first stop bit low.
        cfg_data_bits = 2'd3; cfg_stop_bits = 1'b0; cfg_par_en = 1'b0;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, -1);
        check("8n1_stop_data", rx_data, 8'h81);
        check("8n1_stop_ferr", rx_ferr, 1'b1);
        accept("8n1_stop_accept");
        repeat (4) @(negedge app_clk);

        // Short low glitch on an idle line is rejected as a false start.
        rxd = 1'b0;
        repeat (10) @(negedge app_clk);
        check("glitch_busy_hi", rx_busy, 1'b1);
        repeat (10) @(negedge app_clk);
        rxd = 1'b1;
        repeat (40) @(negedge app_clk);
        check("glitch_busy_lo", rx_busy,  1'b0);
        check("glitch_valid",   rx_valid, 1'b0);

        // Disable mid-frame aborts without output.
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4, -1);
        cfg_rx_en = 1'b0;
        @(negedge app_clk);
        check("abort_busy", rx_busy, 1'b0);
        cfg_rx_en = 1'b1;
        repeat (2 * bit_cyc) @(negedge app_clk);
        check("abort_valid", rx_valid, 1'b0);

        // Back-to-back frames without ready: second is dropped with one overrun.
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, -1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, -1);
        check("ovr_data",  rx_data,  8'h11);
        check("ovr_count", ovr_cnt,  1);
        check("ovr_valid", rx_valid, 1'b1);
        accept("ovr_accept");
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, -1);
        check("post_ovr_data",  rx_data,  8'h33);
        check("post_ovr_valid", rx_valid, 1'b1);
        check("post_ovr_count", ovr_cnt,  1);

        // Reset during DATA of 0x5A while 0x33 is still held.
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 4, -1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_data",  rx_data,  8'h00);
        check("mid_rst_busy",  rx_busy,  1'b0);
        repeat (2) @(negedge app_clk);
        reset_n = 1'b1;
        repeat (5) @(negedge app_clk);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, -1);
        check("c3_valid", rx_valid, 1'b1);
        check("c3_data",  rx_data,  8'hC3);
        check("c3_perr",  rx_perr,  1'b0);
        check("c3_ferr",  rx_ferr,  1'b0);
        accept("c3_accept");

`ifdef UART_RX_MAJ_VOTE_EN
        // One-cycle glitch at the mid-point of data bit 0 is voted out.
        cfg_baud_div = 16'd0;
        bit_cyc = 16;
        repeat (4) @(negedge app_clk);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 1);
        check("vote_lo_data", rx_data, 8'h00);
        accept("vote_lo_accept");
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 4);
        check("vote_hi_data", rx_data, 8'hFF);
        accept("vote_hi_accept");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
